// File: rtl/buzzer_pkg.sv
// Shared types and helpers for the piezo buzzer tone driver.
// Optional escalation hardware is enabled by defining BUZZER_ESCALATE_EN.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [1:0] CH_NONE = 2'd0;
  localparam logic [1:0] CH_1    = 2'd1;
  localparam logic [1:0] CH_2    = 2'd2;
  localparam logic [1:0] CH_3    = 2'd3;

  localparam int ESC_THRESH = 4;

  // Tone half-period in ticks; an unused channel code maps to 1 tick.
  function automatic int tone_half(input logic [1:0] ch, input int h1, input int h2,
                                   input int h3);
    case (ch)
      CH_1:    return h1;
      CH_2:    return h2;
      CH_3:    return h3;
      default: return 1;
    endcase
  endfunction

  // Highest-index enabled channel wins.
  function automatic logic [1:0] chan_sel(input logic [2:0] en);
    if (en[2])      return CH_3;
    else if (en[1]) return CH_2;
    else if (en[0]) return CH_1;
    else            return CH_NONE;
  endfunction

endpackage

// File: rtl/buzzer_tone_driver_tick_prescaler.sv
// Free-running tick generator: one-clk pulse every PRESCALE clks while run is high.
// clr restarts the count so the first tick lands PRESCALE clks after a channel load.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE) + 1;

  logic [PW-1:0] cnt;

  assign tick = run && (cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/buzzer_tone_driver.sv
// Piezo driver: per-channel square-wave tone gated by an ON/OFF beep cadence.
// Define BUZZER_ESCALATE_EN to add burst counting and the escalated output.
module buzzer_tone_driver
  import buzzer_pkg::*;
#(
  parameter int PRESCALE    = 4,
  parameter int TONE_HALF_1 = 2,
  parameter int TONE_HALF_2 = 3,
  parameter int TONE_HALF_3 = 5,
  parameter int CADENCE_ON  = 16,
  parameter int CADENCE_OFF = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] alarm_en,
  output logic       tone_out,
  output logic [1:0] active_ch,
  output logic       busy,
  output logic [1:0] fsm_state
`ifdef BUZZER_ESCALATE_EN
  ,
  output logic       escalated
`endif
);

  localparam int TONE_MAX = (TONE_HALF_1 > TONE_HALF_2)
                          ? ((TONE_HALF_1 > TONE_HALF_3) ? TONE_HALF_1 : TONE_HALF_3)
                          : ((TONE_HALF_2 > TONE_HALF_3) ? TONE_HALF_2 : TONE_HALF_3);
  localparam int CAD_MAX  = (CADENCE_ON > CADENCE_OFF) ? CADENCE_ON : CADENCE_OFF;
  localparam int TW       = $clog2(TONE_MAX) + 1;
  localparam int CW       = $clog2(CAD_MAX) + 1;

  state_t        state, state_n;
  logic [1:0]    sel, ch_n;
  logic          tone_n, load, tick, run, skip_gap, tone_end, cad_end;
  logic [TW-1:0] tone_cnt, tone_cnt_n;
  logic [CW-1:0] cad_cnt, cad_cnt_n;

  assign sel       = chan_sel(alarm_en);
  assign run       = ena && (state != IDLE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign tone_end  = (tone_cnt == TW'(tone_half(active_ch, TONE_HALF_1, TONE_HALF_2,
                                                TONE_HALF_3) - 1));
  assign cad_end   = (state == ON) ? (cad_cnt == CW'(CADENCE_ON - 1))
                                   : (cad_cnt == CW'(CADENCE_OFF - 1));

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (load),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tone_out  <= 1'b0;
      active_ch <= CH_NONE;
      tone_cnt  <= '0;
      cad_cnt   <= '0;
    end else begin
      state     <= state_n;
      tone_out  <= tone_n;
      active_ch <= ch_n;
      tone_cnt  <= tone_cnt_n;
      cad_cnt   <= cad_cnt_n;
    end
  end

  // Channel changes are evaluated before any tick-driven cadence step.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    if (!ena) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      if (sel != CH_NONE) begin
        load    = 1'b1;
        state_n = ON;
      end
    end else if (sel == CH_NONE) begin
      state_n = IDLE;
    end else if (sel != active_ch) begin
      load    = 1'b1;
      state_n = ON;
    end else if (tick && cad_end) begin
      state_n = ((state == ON) && !skip_gap) ? OFF : ON;
    end
  end

  always_comb begin
    tone_n     = tone_out;
    ch_n       = active_ch;
    tone_cnt_n = tone_cnt;
    cad_cnt_n  = cad_cnt;
    if (state_n == IDLE) begin
      tone_n     = 1'b0;
      ch_n       = CH_NONE;
      tone_cnt_n = '0;
      cad_cnt_n  = '0;
    end else if (load) begin
      tone_n     = 1'b1;
      ch_n       = sel;
      tone_cnt_n = '0;
      cad_cnt_n  = '0;
    end else if (tick && (state == ON)) begin
      if (tone_end) begin
        tone_n     = ~tone_out;
        tone_cnt_n = '0;
      end else begin
        tone_cnt_n = tone_cnt + TW'(1);
      end
      if (cad_end) begin
        cad_cnt_n = '0;
        if (state_n == OFF) begin
          tone_n     = 1'b0;
          tone_cnt_n = '0;
        end
      end else begin
        cad_cnt_n = cad_cnt + CW'(1);
      end
    end else if (tick && (state == OFF)) begin
      if (cad_end) begin
        tone_n     = 1'b1;
        tone_cnt_n = '0;
        cad_cnt_n  = '0;
      end else begin
        cad_cnt_n = cad_cnt + CW'(1);
      end
    end
  end

`ifdef BUZZER_ESCALATE_EN
  logic [2:0] burst_cnt;

  assign skip_gap  = (burst_cnt >= 3'(ESC_THRESH));
  assign escalated = skip_gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (load || (state_n == IDLE)) begin
      burst_cnt <= '0;
    end else if ((state == ON) && (state_n == OFF) && (burst_cnt != 3'd7)) begin
      burst_cnt <= burst_cnt + 3'd1;
    end
  end
`else
  assign skip_gap = 1'b0;
`endif

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Directed bench for buzzer_tone_driver: expectations queued per checkpoint, compared at negedge.
// Build with BUZZER_ESCALATE_EN defined to also exercise gap skipping.
module tb_buzzer_tone_driver;
  import buzzer_pkg::*;

  localparam int W = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] alarm_en;
  logic       tone_out;
  logic [1:0] active_ch;
  logic       busy;
  logic [1:0] fsm_state;
  logic       esc_obs;
  logic [W-1:0] obs;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           when_q[$];
  int           checks = 0;
  int           errors = 0;
  int           edge_no = 0;

  always #5 clk = ~clk;

  buzzer_tone_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .alarm_en  (alarm_en),
    .tone_out  (tone_out),
    .active_ch (active_ch),
    .busy      (busy),
    .fsm_state (fsm_state)
`ifdef BUZZER_ESCALATE_EN
    ,
    .escalated (esc_obs)
`endif
  );

`ifndef BUZZER_ESCALATE_EN
  assign esc_obs = 1'b0;
`endif

  assign obs = {fsm_state, esc_obs, busy, active_ch, tone_out};

  function automatic logic [W-1:0] pk(input logic [1:0] st, input logic e, input logic b,
                                      input logic [1:0] ch, input logic t);
    return {st, e, b, ch, t};
  endfunction

  task automatic expect_at(input int k, input string tag, input logic [W-1:0] e);
    when_q.push_back(k);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic goto(input int k);
    repeat (k - edge_no) @(negedge clk);
    if (k > edge_no) edge_no = k;
  endtask

  task automatic compare(input logic [W-1:0] o);
    logic [W-1:0] e;
    string        t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (state,esc,busy,ch,tone)", t, o, e);
    end
  endtask

  task automatic drain();
    int k;
    while (when_q.size() > 0) begin
      k = when_q.pop_front();
      goto(k);
      compare(obs);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    ena      = 1'b1;
    alarm_en = 3'b000;
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b0;
    alarm_en = 3'b000;
    repeat (2) @(negedge clk);
    expect_at(edge_no, "reset_state", pk(IDLE, 0, 0, CH_NONE, 0));
    drain();

    // Channel 1 full ON/OFF cycle: half-period 8 clks, OFF at 65, back ON at 97.
    rst_n    = 1'b1;
    ena      = 1'b1;
    alarm_en = 3'b001;
    edge_no  = 0;
    expect_at(1,   "t1_load",        pk(ON,  0, 1, CH_1, 1));
    expect_at(8,   "t1_pre_toggle",  pk(ON,  0, 1, CH_1, 1));
    expect_at(9,   "t1_toggle",      pk(ON,  0, 1, CH_1, 0));
    expect_at(17,  "t1_toggle2",     pk(ON,  0, 1, CH_1, 1));
    expect_at(64,  "t1_last_on",     pk(ON,  0, 1, CH_1, 0));
    expect_at(65,  "t1_off",         pk(OFF, 0, 1, CH_1, 0));
    expect_at(96,  "t1_gap_end",     pk(OFF, 0, 1, CH_1, 0));
    expect_at(97,  "t1_reon",        pk(ON,  0, 1, CH_1, 1));
    expect_at(105, "t1_reon_toggle", pk(ON,  0, 1, CH_1, 0));
    drain();

    // Preemption by channel 3, then all enables dropped during OFF.
    do_reset();
    alarm_en = 3'b001;
    expect_at(20, "t2_before", pk(ON, 0, 1, CH_1, 1));
    drain();
    alarm_en = 3'b101;
    expect_at(21, "t2_preempt",     pk(ON,  0, 1, CH_3, 1));
    expect_at(40, "t2_pre_toggle",  pk(ON,  0, 1, CH_3, 1));
    expect_at(41, "t2_toggle",      pk(ON,  0, 1, CH_3, 0));
    expect_at(61, "t2_toggle2",     pk(ON,  0, 1, CH_3, 1));
    expect_at(85, "t2_off",         pk(OFF, 0, 1, CH_3, 0));
    expect_at(90, "t3_in_off",      pk(OFF, 0, 1, CH_3, 0));
    drain();
    alarm_en = 3'b000;
    expect_at(91, "t3_idle", pk(IDLE, 0, 0, CH_NONE, 0));
    drain();

    // Channel 2 with ena dropped mid-ON and restored.
    do_reset();
    alarm_en = 3'b010;
    expect_at(1,  "t4_load",   pk(ON, 0, 1, CH_2, 1));
    expect_at(13, "t4_toggle", pk(ON, 0, 1, CH_2, 0));
    expect_at(15, "t4_mid_on", pk(ON, 0, 1, CH_2, 0));
    drain();
    ena = 1'b0;
    expect_at(16, "t4_ena_off",  pk(IDLE, 0, 0, CH_NONE, 0));
    expect_at(18, "t4_ena_hold", pk(IDLE, 0, 0, CH_NONE, 0));
    drain();
    ena = 1'b1;
    expect_at(19, "t4_reload",      pk(ON, 0, 1, CH_2, 1));
    expect_at(30, "t4_pre_toggle",  pk(ON, 0, 1, CH_2, 1));
    expect_at(31, "t4_toggle",      pk(ON, 0, 1, CH_2, 0));
    drain();

    // Asynchronous reset mid-burst, then a clean channel 3 sequence.
    do_reset();
    alarm_en = 3'b100;
    expect_at(10, "t5_pre_reset", pk(ON, 0, 1, CH_3, 1));
    drain();
    #2 rst_n = 1'b0;
    #1;
    expect_at(edge_no, "t5_async_reset", pk(IDLE, 0, 0, CH_NONE, 0));
    drain();
    @(negedge clk);
    rst_n   = 1'b1;
    edge_no = 0;
    expect_at(1,  "t5_load",       pk(ON, 0, 1, CH_3, 1));
    expect_at(20, "t5_pre_toggle", pk(ON, 0, 1, CH_3, 1));
    expect_at(21, "t5_toggle",     pk(ON, 0, 1, CH_3, 0));
    drain();

`ifdef BUZZER_ESCALATE_EN
    // Four gapped bursts, then a continuous tone with escalated high.
    do_reset();
    alarm_en = 3'b001;
    expect_at(161, "t6_gap2",       pk(OFF, 0, 1, CH_1, 0));
    expect_at(352, "t6_burst4_end", pk(ON,  0, 1, CH_1, 0));
    expect_at(353, "t6_gap4",       pk(OFF, 1, 1, CH_1, 0));
    expect_at(360, "t6_gap4_mid",   pk(OFF, 1, 1, CH_1, 0));
    expect_at(385, "t6_burst5",     pk(ON,  1, 1, CH_1, 1));
    expect_at(449, "t6_no_gap",     pk(ON,  1, 1, CH_1, 1));
    expect_at(457, "t6_cont1",      pk(ON,  1, 1, CH_1, 0));
    expect_at(465, "t6_cont2",      pk(ON,  1, 1, CH_1, 1));
    drain();
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_tone_driver.md
Name: buzzer_tone_driver

Overview:
Downstream of the sensor alarm stage. Consumes its three buzzer enable levels and drives one piezo pin with a distinct audible square-wave tone per alarm channel, gated by an on/off beep cadence. When several enables are active, the highest-index channel has priority. Outputs go to uo_out pins.

Parameters:
PRESCALE, 4, clk cycles per tick; must be ≥2.
TONE_HALF_1, 2, tone half-period in ticks for channel 1 (alarm_en[0]).
TONE_HALF_2, 3, tone half-period in ticks for channel 2 (alarm_en[1]).
TONE_HALF_3, 5, tone half-period in ticks for channel 3 (alarm_en[2]).
CADENCE_ON, 16, ticks per ON burst.
CADENCE_OFF, 8, ticks per silent gap.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  block enable; low = synchronous clear to IDLE
alarm_en  in  3  buzzer enable levels from the alarm stage; bit0=ch1, bit1=ch2, bit2=ch3
tone_out  out  1  piezo drive, registered
active_ch  out  2  latched channel: 0=none, 1..3
busy  out  1  high in ON or OFF

Behaviour:
- Reset: state=IDLE, tone_out=0, active_ch=0, busy=0, all counters 0.
- Tick: the prescaler counts 0..PRESCALE-1 while state≠IDLE and ena=1. tick pulses one clk when count=PRESCALE-1. The prescaler clears on every channel load.
- Channel select: sel = 3 if alarm_en[2], else 2 if alarm_en[1], else 1 if alarm_en[0], else 0.
- "Load": active_ch<=sel, state<=ON, tone_out<=1, and clear the prescaler, tone count and cadence count.
- IDLE: on a clk edge where ena=1 and sel≠0, load. tone_out rises 1 clk after alarm_en is sampled.
- ON:
  - On each tick the tone count increments.
  - When tone count = TONE_HALF[active_ch]-1 at a tick, toggle tone_out and clear the tone count. First toggle is TONE_HALF×PRESCALE clks after load.
  - On each tick the cadence count increments. At CADENCE_ON-1: state<=OFF, tone_out<=0, clear counts.
- OFF:
  - tone_out=0.
  - At cadence count CADENCE_OFF-1 on a tick:
    - if alarm_en[active_ch-1] is still 1, re-enter ON with tone_out<=1 and the same channel (prescaler not cleared);
    - otherwise evaluate "change" below.
- Change (checked every clk in ON/OFF; takes priority over tick actions):
  - If sel≠active_ch and sel≠0, load sel. This covers both preemption by a higher channel and fall-back to a lower one.
  - If sel=0, go to IDLE next clk: tone_out=0, active_ch=0.
- ena=0: synchronous forced IDLE with all outputs 0. Re-asserting ena with enables present loads on the next edge.
- Async reset mid-burst returns to reset values immediately. No state survives.
- Counter widths are $clog2 of the max relevant parameter + 1. Counters never wrap, because they clear at their terminal compare.
- busy = (state≠IDLE), registered consistently with state.

Optional Feature:
BUZZER_ESCALATE_EN
- Defined: a 3-bit saturating burst counter increments at each ON→OFF transition for the same channel and clears on load or IDLE. Once it reaches 4, the OFF gap is skipped: ON→ON is a continuous tone and the cadence count still cycles. Adds output escalated (1 bit), high while burst count ≥4.
- Undefined: no burst counter and no escalated port; cadence is always ON/OFF.

Decomposition:
- Package buzzer_pkg holds:
  - state typedef (IDLE, ON, OFF);
  - channel codes CH_NONE=0, CH_1..CH_3;
  - escalation threshold constant (4);
  - a tone-half lookup function mapping channel → parameter.
- Sub-module tick_prescaler (PRESCALE param; clk, rst_n, run, clr → tick) is natural. The FSM and tone/cadence counters stay in the top.

Test Plan:
- Reset with default params and alarm_en=001 asserted at clk 0:
  - tone_out=1 at clk1;
  - toggles every 8 clks;
  - drops to 0 and busy stays 1 at clk 65 (OFF);
  - tone_out=1 again at clk 97.
- alarm_en=001, then 101 at clk 20: active_ch becomes 3 at clk 21, tone_out=1, next toggle 20 clks later (5×4).
- In OFF, deassert all enables: next clk state=IDLE, busy=0, active_ch=0, tone_out stays 0.
- ena dropped mid-ON with alarm_en=010: next clk all outputs 0. ena restored: load ch2, tone_out=1 one clk later, half-period 12 clks.
- rst_n pulsed low asynchronously mid-toggle: outputs 0 without a clock edge. After release with alarm_en=100, the normal ch3 sequence follows.
- BUZZER_ESCALATE_EN defined, alarm_en=001 held: the first 4 bursts each end in an 8-tick gap. From the 5th burst on, tone_out toggles continuously with no gap and escalated=1.
